fetch_ctrl: RTL

//  Fetch-stage sequencer between instruction memory and the F__D interface.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_fifo.sv | 68 ++++++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    localparam int c_addr_bits = 32;
    localparam int c_inst_bits = 32;
    localparam int c_pc_incr   = 4;

    typedef logic [c_addr_bits-1:0] addr_t;
    typedef logic [c_inst_bits-1:0] inst_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// Small FIFO of issued PCs; the head pairs with the next imem response.
module fetch_pc_fifo
    import fetch_pkg::*;
#(
    parameter int p_width = 32,
    parameter int p_depth = 2,
    localparam int c_cnt_bits = cnt_bits(p_depth),
    localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [p_width-1:0]    push_data,
    input  logic                  pop,
    output logic [c_cnt_bits-1:0] count,
    output logic [p_width-1:0]    head
);

    logic [p_width-1:0]    mem [p_depth];
    logic [c_ptr_bits-1:0] wr_ptr_reg;
    logic [c_ptr_bits-1:0] rd_ptr_reg;
    logic [c_cnt_bits-1:0] count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    // Wrap a pointer at the configured depth (depth need not fill the pointer range).
    function automatic logic [c_ptr_bits-1:0] ptr_inc(input logic [c_ptr_bits-1:0] ptr);
        return (ptr == c_ptr_bits'(p_depth - 1)) ? '0 : ptr + c_ptr_bits'(1);
    endfunction

    // Ignore pop on empty and push on full so occupancy can never go out of range.
    always_comb begin
        push_ok = push && (count_reg != c_cnt_bits'(p_depth));
        pop_ok  = pop && (count_reg != '0);
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + c_cnt_bits'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - c_cnt_bits'(1);
            end
        end
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues sequential imem reads, pairs responses with
// their PCs, presents them to decode and handles squash redirects by
// discarding every response that was already in flight.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                     p_addr_bits     = 32,
    parameter int                     p_inst_bits     = 32,
    parameter logic [p_addr_bits-1:0] p_rst_addr      = '0,
    parameter int                     p_max_in_flight = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [p_addr_bits-1:0] mem_req_addr,
    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic [p_inst_bits-1:0] mem_resp_data,
    output logic                   d_val,
    input  logic                   d_rdy,
    output logic [p_addr_bits-1:0] d_pc,
    output logic [p_inst_bits-1:0] d_inst,
    input  logic                   d_squash,
    input  logic [p_addr_bits-1:0] d_branch_target
);

    localparam int c_cnt_bits = cnt_bits(p_max_in_flight);

    logic [p_addr_bits-1:0] fetch_pc_reg;
    logic [p_addr_bits-1:0] fetch_pc_next;
    logic [c_cnt_bits-1:0]  drop_cnt_reg;
    logic [c_cnt_bits-1:0]  drop_cnt_next;
    logic [c_cnt_bits-1:0]  count;
    logic [p_addr_bits-1:0] head;
    logic                   fifo_empty;
    logic                   dropping;
    logic                   req_fire;
    logic                   pop;

    fetch_pc_fifo #(
        .p_width (p_addr_bits),
        .p_depth (p_max_in_flight)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // Request/response handshakes and next-state for fetch PC and stale-response count.
    always_comb begin
        fifo_empty    = (count == '0);
        dropping      = (drop_cnt_reg != '0);
        mem_req_val   = !rst && !d_squash && (count < c_cnt_bits'(p_max_in_flight));
        mem_req_addr  = fetch_pc_reg;
        req_fire      = mem_req_val && mem_req_rdy;
        mem_resp_rdy  = 1'b0;
        d_val         = 1'b0;
        d_pc          = head;
        d_inst        = mem_resp_data;
        if (!rst) begin
            if (dropping) begin
                // Stale responses are swallowed without involving decode.
                mem_resp_rdy = 1'b1;
            end else begin
                mem_resp_rdy = d_rdy || d_squash;
                d_val        = mem_resp_val && !d_squash && !fifo_empty;
            end
        end
        pop           = mem_resp_val && mem_resp_rdy && !fifo_empty;
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (d_squash) begin
            // Everything still outstanding after this cycle's pop is stale.
            fetch_pc_next = d_branch_target;
            drop_cnt_next = count - c_cnt_bits'(pop);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + p_addr_bits'(c_pc_incr);
            end
            if (dropping && pop) begin
                drop_cnt_next = drop_cnt_reg - c_cnt_bits'(1);
            end
        end
    end

    // Fetch PC and stale-response counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= p_rst_addr;
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // A response with nothing outstanding is an imem protocol error.
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(mem_resp_val && fifo_empty));

    // The stale count can never exceed the number of outstanding requests.
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_reg <= count);

endmodule
